// File: rtl/io_bus_pkg.sv
// rtl/io_bus_pkg.sv - shared types and constants for the I/O bus arbiter
package io_bus_pkg;

    localparam int DEV_W  = 3;
    localparam int REG_W  = 2;
    localparam int DATA_W = 16;

    localparam logic [DEV_W-1:0] IDLE_DEV_DEFAULT = 3'd7;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way combinational arbiter, round-robin or fixed A priority
module rr_arb2
    import io_bus_pkg::*;
(
    input  logic cpu_priority,
    input  logic req_a,
    input  logic req_b,
    input  logic last_owner,
    output logic grant,
    output logic winner
);

    always_comb begin
        grant = req_a | req_b;
        if (req_a && req_b) begin
            winner = cpu_priority ? OWNER_A : ~last_owner;
        end else if (req_b) begin
            winner = OWNER_B;
        end else begin
            winner = OWNER_A;
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// rtl/io_bus_arbiter.sv - sequences CPU and DMA accesses onto the shared I/O decode bus
module io_bus_arbiter
    import io_bus_pkg::*;
#(
    parameter int               WAIT_CYCLES  = 1,
    parameter int               NUM_MAPPED   = 4,
    parameter bit               CPU_PRIORITY = 1'b0,
    parameter logic [DEV_W-1:0] IDLE_DEV     = IDLE_DEV_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [DEV_W-1:0]  a_dev,
    input  logic [REG_W-1:0]  a_reg,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic              a_err,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [DEV_W-1:0]  b_dev,
    input  logic [REG_W-1:0]  b_reg,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic              b_err,
    output logic [DATA_W-1:0] b_rdata,
    output logic [DEV_W-1:0]  io_dev_sel,
    output logic [REG_W-1:0]  io_reg_sel,
    output logic              io_we,
    output logic [DATA_W-1:0] io_data_out,
    input  logic [DATA_W-1:0] io_data_in,
    output logic              busy,
    output logic              owner
);

    state_t            state, state_d;
    logic [3:0]        cnt, cnt_d;
    logic              lat_we, lat_we_d;
    logic              owner_d, busy_d;
    logic [DEV_W-1:0]  io_dev_sel_d;
    logic [REG_W-1:0]  io_reg_sel_d;
    logic              io_we_d;
    logic [DATA_W-1:0] io_data_out_d;
    logic              a_ack_d, a_err_d, b_ack_d, b_err_d;
    logic [DATA_W-1:0] a_rdata_d, b_rdata_d;
    logic              grant, winner, unmapped;

    rr_arb2 u_arb (
        .cpu_priority (CPU_PRIORITY),
        .req_a        (a_req),
        .req_b        (b_req),
        .last_owner   (owner),
        .grant        (grant),
        .winner       (winner)
    );

    // The bus fields latched at grant double as the transaction record.
    assign unmapped = int'(io_dev_sel) >= NUM_MAPPED;

    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        lat_we_d      = lat_we;
        owner_d       = owner;
        io_dev_sel_d  = io_dev_sel;
        io_reg_sel_d  = io_reg_sel;
        io_data_out_d = io_data_out;
        io_we_d       = 1'b0;
        a_ack_d       = 1'b0;
        a_err_d       = 1'b0;
        b_ack_d       = 1'b0;
        b_err_d       = 1'b0;
        a_rdata_d     = a_rdata;
        b_rdata_d     = b_rdata;
        case (state)
            ST_IDLE: begin
                io_dev_sel_d = IDLE_DEV;
                if (grant) begin
                    owner_d       = winner;
                    lat_we_d      = winner ? b_we : a_we;
                    io_dev_sel_d  = winner ? b_dev : a_dev;
                    io_reg_sel_d  = winner ? b_reg : a_reg;
                    io_data_out_d = winner ? b_wdata : a_wdata;
                    state_d       = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (unmapped) begin
                    state_d      = ST_RESP;
                    io_dev_sel_d = IDLE_DEV;
                    a_ack_d      = (owner == OWNER_A);
                    a_err_d      = (owner == OWNER_A);
                    b_ack_d      = (owner == OWNER_B);
                    b_err_d      = (owner == OWNER_B);
                end else begin
                    state_d = ST_ACCESS;
                    cnt_d   = 4'(WAIT_CYCLES);
                    io_we_d = lat_we && (WAIT_CYCLES == 0);
                end
            end
            ST_ACCESS: begin
                if (cnt == 4'd0) begin
                    state_d      = ST_RESP;
                    io_dev_sel_d = IDLE_DEV;
                    a_ack_d      = (owner == OWNER_A);
                    b_ack_d      = (owner == OWNER_B);
                    if (!lat_we && owner == OWNER_A) a_rdata_d = io_data_in;
                    if (!lat_we && owner == OWNER_B) b_rdata_d = io_data_in;
                end else begin
                    cnt_d   = cnt - 4'd1;
                    io_we_d = lat_we && (cnt == 4'd1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d      = ST_IDLE;
                io_dev_sel_d = IDLE_DEV;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            lat_we      <= 1'b0;
            owner       <= OWNER_B;
            busy        <= 1'b0;
            io_dev_sel  <= IDLE_DEV;
            io_reg_sel  <= '0;
            io_we       <= 1'b0;
            io_data_out <= '0;
            a_ack       <= 1'b0;
            a_err       <= 1'b0;
            b_ack       <= 1'b0;
            b_err       <= 1'b0;
            a_rdata     <= '0;
            b_rdata     <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            lat_we      <= lat_we_d;
            owner       <= owner_d;
            busy        <= busy_d;
            io_dev_sel  <= io_dev_sel_d;
            io_reg_sel  <= io_reg_sel_d;
            io_we       <= io_we_d;
            io_data_out <= io_data_out_d;
            a_ack       <= a_ack_d;
            a_err       <= a_err_d;
            b_ack       <= b_ack_d;
            b_err       <= b_err_d;
            a_rdata     <= a_rdata_d;
            b_rdata     <= b_rdata_d;
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb/tb_io_bus_arbiter.sv - randomized self-checking bench with a transaction-level model
`timescale 1ns/1ps
module tb_io_bus_arbiter;
    import io_bus_pkg::*;

    localparam int W  = 1;
    localparam int NM = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [2:0]  a_dev, b_dev;
    logic [1:0]  a_reg, b_reg;
    logic [15:0] a_wdata, b_wdata, io_data_in;
    logic        a_ack, a_err, b_ack, b_err, io_we, busy, owner;
    logic [15:0] a_rdata, b_rdata, io_data_out;
    logic [2:0]  io_dev_sel;
    logic [1:0]  io_reg_sel;
    logic        p_a_ack, p_a_err, p_b_ack, p_b_err, p_io_we, p_busy, p_owner;
    logic [15:0] p_a_rdata, p_b_rdata, p_io_data_out;
    logic [2:0]  p_io_dev_sel;
    logic [1:0]  p_io_reg_sel;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    io_bus_arbiter #(.WAIT_CYCLES(W), .NUM_MAPPED(NM), .CPU_PRIORITY(1'b0), .IDLE_DEV(3'd7)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_dev(a_dev), .a_reg(a_reg), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_dev(b_dev), .b_reg(b_reg), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
        .io_dev_sel(io_dev_sel), .io_reg_sel(io_reg_sel), .io_we(io_we),
        .io_data_out(io_data_out), .io_data_in(io_data_in), .busy(busy), .owner(owner)
    );

    io_bus_arbiter #(.WAIT_CYCLES(0), .NUM_MAPPED(NM), .CPU_PRIORITY(1'b1), .IDLE_DEV(3'd7)) u_pri (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_dev(a_dev), .a_reg(a_reg), .a_wdata(a_wdata),
        .a_ack(p_a_ack), .a_err(p_a_err), .a_rdata(p_a_rdata),
        .b_req(b_req), .b_we(b_we), .b_dev(b_dev), .b_reg(b_reg), .b_wdata(b_wdata),
        .b_ack(p_b_ack), .b_err(p_b_err), .b_rdata(p_b_rdata),
        .io_dev_sel(p_io_dev_sel), .io_reg_sel(p_io_reg_sel), .io_we(p_io_we),
        .io_data_out(p_io_data_out), .io_data_in(io_data_in), .busy(p_busy), .owner(p_owner)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: one grant at a time, outputs derived from the cycle offset k since grant.
    bit          m_active;
    int          m_k, m_last;
    logic        m_port, m_we, m_owner;
    logic [2:0]  m_dev;
    logic [1:0]  m_reg;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata [2];
    logic [1:0]  e_ack, e_err;
    logic [2:0]  e_dev;
    logic [1:0]  e_reg;
    logic [15:0] e_dout;
    logic        e_we, e_busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0; m_owner = 1'b1; m_rdata[0] = '0; m_rdata[1] = '0;
            e_ack = '0; e_err = '0; e_dev = 3'd7; e_reg = '0; e_dout = '0; e_we = 1'b0; e_busy = 1'b0;
        end else begin
            if (m_active) begin
                m_k++;
                if (m_k > m_last) m_active = 1'b0;
            end else if (a_req || b_req) begin
                if (a_req && b_req) m_port = ~m_owner;
                else m_port = b_req;
                m_owner = m_port;
                m_we    = m_port ? b_we : a_we;
                m_dev   = m_port ? b_dev : a_dev;
                m_reg   = m_port ? b_reg : a_reg;
                m_wdata = m_port ? b_wdata : a_wdata;
                m_active = 1'b1;
                m_k      = 1;
                m_last   = (int'(m_dev) < NM) ? 3 + W : 2;
            end
            e_ack = '0; e_err = '0;
            if (m_active) begin
                e_busy = 1'b1;
                e_reg  = m_reg;
                e_dout = m_wdata;
                e_dev  = (m_k < m_last) ? m_dev : 3'd7;
                e_we   = m_we && (int'(m_dev) < NM) && (m_k == 2 + W);
                if (m_k == m_last) begin
                    e_ack[m_port] = 1'b1;
                    e_err[m_port] = (int'(m_dev) >= NM);
                    if (int'(m_dev) < NM && !m_we) m_rdata[m_port] = io_data_in;
                end
            end else begin
                e_busy = 1'b0; e_dev = 3'd7; e_we = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("a_ack",   32'(a_ack),       32'(e_ack[0]));
        check("b_ack",   32'(b_ack),       32'(e_ack[1]));
        check("a_err",   32'(a_err),       32'(e_err[0]));
        check("b_err",   32'(b_err),       32'(e_err[1]));
        check("a_rdata", 32'(a_rdata),     32'(m_rdata[0]));
        check("b_rdata", 32'(b_rdata),     32'(m_rdata[1]));
        check("dev_sel", 32'(io_dev_sel),  32'(e_dev));
        check("reg_sel", 32'(io_reg_sel),  32'(e_reg));
        check("data_out",32'(io_data_out), 32'(e_dout));
        check("io_we",   32'(io_we),       32'(e_we));
        check("busy",    32'(busy),        32'(e_busy));
        check("owner",   32'(owner),       32'(m_owner));
    end

    logic [2:0] tr_dev [0:10];
    logic [1:0] tr_reg [0:10];
    logic       tr_we  [0:10];
    logic       tr_ack [0:10];
    logic       tr_err [0:10];
    logic [15:0] tr_dout [0:10];

    task automatic issue(input logic port, input logic we, input logic [2:0] dev,
                         input logic [1:0] rg, input logic [15:0] wd, input logic [15:0] din);
        io_data_in = din;
        if (port) begin b_req = 1'b1; b_we = we; b_dev = dev; b_reg = rg; b_wdata = wd; end
        else      begin a_req = 1'b1; a_we = we; a_dev = dev; a_reg = rg; a_wdata = wd; end
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            tr_dev[c] = io_dev_sel; tr_reg[c] = io_reg_sel; tr_we[c] = io_we; tr_dout[c] = io_data_out;
            tr_ack[c] = port ? b_ack : a_ack;
            tr_err[c] = port ? b_err : a_err;
            if (tr_ack[c]) begin
                if (port) b_req = 1'b0; else a_req = 1'b0;
            end
        end
    endtask

    function automatic int count_we();
        int n = 0;
        for (int c = 1; c <= 10; c++) n += int'(tr_we[c]);
        return n;
    endfunction

    int  ord [8];
    int  n_ord, p_a_cnt, p_b_cnt, found;

    initial begin
        rst_n = 1'b0;
        a_req = 0; a_we = 0; a_dev = 0; a_reg = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_dev = 0; b_reg = 0; b_wdata = 0;
        io_data_in = 0;
        repeat (3) @(negedge clk);
        check("rst_dev_sel", 32'(io_dev_sel), 32'd7);
        check("rst_owner",   32'(owner),      32'd1);
        check("rst_busy",    32'(busy),       32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(1'b0, 1'b0, 3'd2, 2'd1, 16'h0000, 16'hBEEF);
        check("rd_dev_c1", 32'(tr_dev[1]), 32'd2);
        check("rd_dev_c3", 32'(tr_dev[3]), 32'd2);
        check("rd_dev_c4", 32'(tr_dev[4]), 32'd7);
        check("rd_ack_c3", 32'(tr_ack[3]), 32'd0);
        check("rd_ack_c4", 32'(tr_ack[4]), 32'd1);
        check("rd_ack_c5", 32'(tr_ack[5]), 32'd0);
        check("rd_err",    32'(tr_err[4]), 32'd0);
        check("rd_rdata",  32'(a_rdata),   32'hBEEF);
        check("rd_we_cnt", 32'(count_we()), 32'd0);

        issue(1'b0, 1'b1, 3'd0, 2'd3, 16'h1234, 16'h0F0F);
        check("wr_we_c3",   32'(tr_we[3]),   32'd1);
        check("wr_we_cnt",  32'(count_we()), 32'd1);
        check("wr_dout_c3", 32'(tr_dout[3]), 32'h1234);
        check("wr_reg_c3",  32'(tr_reg[3]),  32'd3);
        check("wr_ack_c4",  32'(tr_ack[4]),  32'd1);
        check("wr_rdata",   32'(a_rdata),    32'hBEEF);

        issue(1'b1, 1'b0, 3'd5, 2'd0, 16'h0000, 16'hAAAA);
        check("um_ack_c2",  32'(tr_ack[2]),  32'd1);
        check("um_err_c2",  32'(tr_err[2]),  32'd1);
        check("um_ack_c3",  32'(tr_ack[3]),  32'd0);
        check("um_we_cnt",  32'(count_we()), 32'd0);
        check("um_rdata",   32'(b_rdata),    32'h0000);

        // both ports hold requests from reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        a_req = 1; a_we = 0; a_dev = 3'd1; b_req = 1; b_we = 0; b_dev = 3'd3;
        for (int i = 0; i < 8; i++) ord[i] = -1;
        n_ord = 0; p_a_cnt = 0; p_b_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            io_data_in = 16'(c);
            if (a_ack && n_ord < 8) begin ord[n_ord] = 0; n_ord++; end
            if (b_ack && n_ord < 8) begin ord[n_ord] = 1; n_ord++; end
            p_a_cnt += int'(p_a_ack);
            p_b_cnt += int'(p_b_ack);
        end
        a_req = 0; b_req = 0;
        for (int i = 0; i < 4; i++) check("rr_order", 32'(ord[i]), 32'(i % 2));
        check("pri_b_starved", 32'(p_b_cnt), 32'd0);
        check("pri_a_served",  32'(p_a_cnt >= 6), 32'd1);
        repeat (8) @(negedge clk);

        // reset while a write strobe is on the bus
        a_req = 1; a_we = 1; a_dev = 3'd1; a_reg = 2'd2; a_wdata = 16'hC0DE;
        found = 0;
        for (int c = 0; c < 10 && found == 0; c++) begin
            @(negedge clk);
            if (io_we) found = 1;
        end
        check("mid_we_seen", 32'(found), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_we",  32'(io_we),      32'd0);
        check("mid_rst_dev", 32'(io_dev_sel), 32'd7);
        check("mid_rst_ack", 32'(a_ack),      32'd0);
        a_req = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, 1'b0, 3'd1, 2'd0, 16'h0000, 16'h5A5A);
        check("post_ack_c4", 32'(tr_ack[4]), 32'd1);
        check("post_rdata",  32'(a_rdata),   32'h5A5A);

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            io_data_in = 16'($urandom);
            if (a_req && a_ack) a_req = 0;
            else if (!a_req && $urandom_range(0, 2) == 0) a_req = 1;
            if (b_req && b_ack) b_req = 0;
            else if (!b_req && $urandom_range(0, 2) == 0) b_req = 1;
            a_we = 1'($urandom); a_dev = 3'($urandom); a_reg = 2'($urandom); a_wdata = 16'($urandom);
            b_we = 1'($urandom); b_dev = 3'($urandom); b_reg = 2'($urandom); b_wdata = 16'($urandom);
        end
        a_req = 0; b_req = 0;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Sequences all I/O accesses onto the shared 8-device I/O select/decode bus: dev_sel[2:0], reg_sel[1:0], we, 16-bit write data and 16-bit read-back.
- Arbitrates between two requesters, the CPU (port A) and a DMA/peripheral master (port B).
- Produces a single-cycle write strobe, a fixed wait window for reads, and a one-cycle ack/err response.
- Parks the bus on an unmapped device when idle, so no device chip-select is asserted spuriously.

Parameters:
- WAIT_CYCLES, 1, extra ACCESS cycles before read capture / write strobe (0..15).
- NUM_MAPPED, 4, devices 0..NUM_MAPPED-1 are decoded; any higher dev index is an error.
- CPU_PRIORITY, 0, 0 = round-robin; 1 = port A always wins ties.
- IDLE_DEV, 3'd7, dev_sel value driven when the bus is idle.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_req  in  1  port A request; held until a_ack.
- a_we  in  1  port A write (1) / read (0).
- a_dev  in  3  port A device index.
- a_reg  in  2  port A register index.
- a_wdata  in  16  port A write data.
- a_ack  out  1  one-cycle completion pulse.
- a_err  out  1  valid with a_ack; unmapped device.
- a_rdata  out  16  read data; valid from a_ack, held until the next A read completes.
- b_req, b_we, b_dev, b_reg, b_wdata, b_ack, b_err, b_rdata  as port A.
- io_dev_sel  out  3  to decoder.
- io_reg_sel  out  2  to decoder.
- io_we  out  1  to decoder; write strobe.
- io_data_out  out  16  to decoder.
- io_data_in  in  16  read-back from decoder.
- busy  out  1  state != IDLE.
- owner  out  1  0 = A, 1 = B; last/current grant.

Behaviour:
- Reset (async, rst_n=0) sets the following immediately:
  - state=IDLE.
  - io_dev_sel=IDLE_DEV, io_reg_sel=0, io_we=0, io_data_out=0.
  - a_ack=b_ack=0, a_err=b_err=0, a_rdata=b_rdata=0.
  - busy=0, owner=1, so A wins the first tie.
- All outputs are registered.
- FSM states are IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Any req: grant, latch we/dev/reg/wdata of the winner, update owner, go to SETUP.
- Arbitration, on simultaneous requests:
  - CPU_PRIORITY=0: grant the port not equal to owner.
  - CPU_PRIORITY=1: grant A.
  - A single request is granted regardless of mode.
- SETUP (1 cycle):
  - Drive io_dev_sel/io_reg_sel/io_data_out from the latched fields; io_we=0.
  - If dev >= NUM_MAPPED: go to RESP with err=1. No io_we pulse; rdata is not updated.
  - Otherwise: counter=WAIT_CYCLES, go to ACCESS.
- ACCESS (WAIT_CYCLES+1 cycles):
  - Bus fields are held stable.
  - In the final cycle (counter==0): io_we=latched we, so a write pulses exactly once.
  - A read captures io_data_in into the owner's rdata at the end of the final cycle.
  - Counter decrements otherwise. Then go to RESP.
- RESP (1 cycle):
  - Owner's ack=1, err as determined.
  - io_we=0; io_dev_sel returns to IDLE_DEV.
  - Go to IDLE.
- Latency, with req sampled at edge 0:
  - Mapped access: ack is high in cycle 3+WAIT_CYCLES (WAIT_CYCLES=1 → cycle 4).
  - Unmapped access: ack is high in cycle 2.
  - Minimum back-to-back spacing is 4+WAIT_CYCLES cycles.
- Requester contract:
  - Drop req in the cycle after ack.
  - A req still high in IDLE is treated as a new request.
  - Request fields are sampled only at grant; later changes are ignored.
- The non-owner's req is ignored while busy and stays pending; it wins in the next IDLE under round-robin.
- Reset mid-access: the transfer is aborted, no ack is issued, and io_we drops asynchronously.

Decomposition:
- Package io_bus_pkg: state encoding (IDLE/SETUP/ACCESS/RESP), OWNER_A/OWNER_B constants, default IDLE_DEV, widths DEV_W=3, REG_W=2, DATA_W=16.
- Sub-module rr_arb2: 2-way arbiter with priority-mode input.
  - Inputs: req_a, req_b, last owner.
  - Outputs: grant and winner.
  - Purely combinational.

Test Plan:
- A read, dev 2, reg 1, io_data_in=16'hBEEF, WAIT_CYCLES=1 → io_dev_sel=2 in cycles 1-3; a_ack=1 in cycle 4 only; a_rdata=16'hBEEF; a_err=0; io_we never 1.
- A write, dev 0, reg 3, wdata 16'h1234 → io_we high exactly one cycle (cycle 3) with io_data_out=16'h1234 and io_reg_sel=3; a_ack in cycle 4.
- B read of dev 5 (NUM_MAPPED=4) → b_ack and b_err high in cycle 2; io_we stays 0; b_rdata unchanged.
- A and B request together from reset, both held, CPU_PRIORITY=0 → grant order A, B, A, B:
  - owner toggles each grant.
  - With CPU_PRIORITY=1, A is served every time while it keeps requesting.
- Idle check → io_dev_sel=7 and io_we=0 whenever busy=0.
- rst_n pulsed low during ACCESS of a write → io_we=0 and io_dev_sel=7 immediately; no ack; the next request completes normally.
